// File: rtl/mic_array_pkg.sv
// Shared constants, accumulator width derivation and FSM states for the
// microphone lag estimator.
package mic_array_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int FRAME_LEN = 256;
  localparam int MAX_LAG   = 8;
  localparam int LAG_W     = 6;

  // Sum of FRAME_LEN full-scale products cannot overflow this width.
  function automatic int acc_w(input int sw, input int fl);
    return 2 * sw + $clog2(fl);
  endfunction

  localparam int ACC_W = acc_w(SAMPLE_W, FRAME_LEN);

  typedef enum logic [1:0] {FILL, COMPUTE, DONE} mic_state_e;

  // Magnitude of a lag; |k| <= 31 always fits unsigned in LAG_W bits.
  function automatic logic [LAG_W-1:0] lag_abs(input logic signed [LAG_W-1:0] k);
    return k[LAG_W-1] ? LAG_W'(-k) : LAG_W'(k);
  endfunction
endpackage

// File: rtl/mic_lag_estimator_if.sv
// Sample-pair input and lag-result output bundle of the lag estimator.
interface mic_lag_estimator_if #(
  parameter int SAMPLE_W = mic_array_pkg::SAMPLE_W,
  parameter int ACC_W    = mic_array_pkg::ACC_W
) (
  input logic clk
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] mic_a;
  logic signed [SAMPLE_W-1:0] mic_b;
  logic signed [5:0]          lag_diff;
  logic                       ena;
  logic signed [ACC_W-1:0]    peak_corr;
  logic                       busy;

  modport master (input clk, output sample_valid, mic_a, mic_b,
                  input lag_diff, ena, peak_corr, busy);
  modport slave  (input clk, input sample_valid, mic_a, mic_b,
                  output lag_diff, ena, peak_corr, busy);
endinterface

// File: rtl/mic_lag_estimator_xcorr_mac.sv
// Multiply-accumulate pipeline: one product per cycle, accumulator is
// reloaded (not added) by the first term of each lag, so no clear cycle.
module xcorr_mac #(
  parameter int SAMPLE_W = mic_array_pkg::SAMPLE_W,
  parameter int ACC_W    = mic_array_pkg::ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       term_vld,
  input  logic                       term_first,
  input  logic                       term_inr,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [ACC_W-1:0]    acc
);
  localparam int PW = 2 * SAMPLE_W;

  logic signed [PW-1:0]    mult;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    prod_vld;
  logic                    prod_first;

  assign mult     = a * b;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Out-of-frame terms enter as zero products so the term count per lag is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod       <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      acc        <= '0;
    end else begin
      prod       <= term_inr ? mult : '0;
      prod_vld   <= term_vld;
      prod_first <= term_first;
      if (prod_vld) acc <= prod_first ? prod_ext : acc + prod_ext;
    end
  end
endmodule

// File: rtl/mic_lag_estimator.sv
// Cross-correlation lag estimator: fills a frame of sample pairs, sweeps
// R(k) for k = -MAX_LAG..+MAX_LAG, and reports the argmax lag.
module mic_lag_estimator import mic_array_pkg::*; #(
  parameter int  SAMPLE_W  = mic_array_pkg::SAMPLE_W,
  parameter int  FRAME_LEN = mic_array_pkg::FRAME_LEN,
  parameter int  MAX_LAG   = mic_array_pkg::MAX_LAG,
  localparam int ACC_W     = acc_w(SAMPLE_W, FRAME_LEN)
) (
  input  logic                       clk_60MHz,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] mic_a,
  input  logic signed [SAMPLE_W-1:0] mic_b,
  output logic signed [LAG_W-1:0]    lag_diff,
  output logic                       ena,
  output logic signed [ACC_W-1:0]    peak_corr,
  output logic                       busy
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(FRAME_LEN + 3);
  localparam int PW = AW + LAG_W + 1;
  localparam logic [CW-1:0]          ISSUE_END = CW'(FRAME_LEN);
  localparam logic [CW-1:0]          CMP_CYC   = CW'(FRAME_LEN + 2);
  localparam logic signed [LAG_W-1:0] K_MIN    = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] K_MAX    = LAG_W'(MAX_LAG);

  mic_state_e state, state_nxt;

  logic [AW-1:0]              wr_idx;
  logic [CW-1:0]              cyc;
  logic signed [LAG_W-1:0]    lag;
  logic signed [PW-1:0]       b_pos;
  logic                       wr_en, issue, inr, cmp, take;
  logic                       term_vld_q, term_first_q, term_inr_q;
  logic signed [SAMPLE_W-1:0] mem_a [FRAME_LEN];
  logic signed [SAMPLE_W-1:0] mem_b [FRAME_LEN];
  logic signed [SAMPLE_W-1:0] rd_a, rd_b;
  logic signed [ACC_W-1:0]    acc, best, best_nxt;
  logic signed [LAG_W-1:0]    best_k, best_k_nxt;

  assign busy  = (state == COMPUTE);
  assign wr_en = (state == FILL) && sample_valid;
  assign issue = (state == COMPUTE) && (cyc < ISSUE_END);
  assign cmp   = (state == COMPUTE) && (cyc == CMP_CYC);
  // B read position n+k; in range only when non-negative and below FRAME_LEN.
  assign b_pos = $signed({{(PW-AW){1'b0}}, cyc[AW-1:0]})
               + $signed({{(PW-LAG_W){lag[LAG_W-1]}}, lag});
  assign inr   = !b_pos[PW-1] && (b_pos[PW-2:AW] == '0);

  // Argmax: strictly larger wins; ties go to the smaller lag magnitude.
  assign take = (lag == K_MIN) || (acc > best) ||
                ((acc == best) && (lag_abs(lag) < lag_abs(best_k)));
  assign best_nxt   = take ? acc : best;
  assign best_k_nxt = take ? lag : best_k;

  // Next-state logic for the frame FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (sample_valid && (&wr_idx)) state_nxt = COMPUTE;
      COMPUTE: if (cmp && (lag == K_MAX))     state_nxt = DONE;
      DONE:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Frame buffers: write port in FILL, registered read port in COMPUTE.
  always_ff @(posedge clk_60MHz) begin
    if (wr_en) begin
      mem_a[wr_idx] <= mic_a;
      mem_b[wr_idx] <= mic_b;
    end
    rd_a <= mem_a[cyc[AW-1:0]];
    rd_b <= mem_b[b_pos[AW-1:0]];
  end

  // State, addressing, argmax tracking and result registers.
  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      state        <= FILL;
      wr_idx       <= '0;
      cyc          <= '0;
      lag          <= K_MIN;
      best         <= '0;
      best_k       <= '0;
      lag_diff     <= '0;
      peak_corr    <= '0;
      ena          <= 1'b0;
      term_vld_q   <= 1'b0;
      term_first_q <= 1'b0;
      term_inr_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      ena          <= 1'b0;
      term_vld_q   <= issue;
      term_first_q <= issue && (cyc == '0);
      term_inr_q   <= issue && inr;
      if (wr_en) wr_idx <= wr_idx + 1'b1;
      if (state == DONE) wr_idx <= '0;
      if (state == COMPUTE) begin
        if (cmp) begin
          cyc    <= '0;
          best   <= best_nxt;
          best_k <= best_k_nxt;
          // Results are latched on the final compare so they are valid with ena in DONE.
          if (lag == K_MAX) begin
            lag       <= K_MIN;
            lag_diff  <= best_k_nxt;
            peak_corr <= best_nxt;
            ena       <= 1'b1;
          end else begin
            lag <= lag + 1'b1;
          end
        end else begin
          cyc <= cyc + 1'b1;
        end
      end
    end
  end

  xcorr_mac #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_mac (
    .clk        (clk_60MHz),
    .rst        (rst),
    .term_vld   (term_vld_q),
    .term_first (term_first_q),
    .term_inr   (term_inr_q),
    .a          (rd_a),
    .b          (rd_b),
    .acc        (acc)
  );
endmodule

// File: tb/tb_mic_lag_estimator.sv
// Directed bench for mic_lag_estimator with a scoreboard of model results.
`timescale 1ns/1ps
module tb_mic_lag_estimator;
  import mic_array_pkg::*;

  localparam int SW = 16;
  localparam int FL = 256;
  localparam int ML = 8;
  localparam int AC = acc_w(SW, FL);
  localparam int L  = (2 * ML + 1) * (FL + 3) + 1;

  typedef struct {
    logic signed [63:0] lag;
    logic signed [63:0] peak;
    int                 cap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   ena_seen = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq [$];

  logic signed [SW-1:0] xs [FL+40];
  logic signed [SW-1:0] fa [FL];
  logic signed [SW-1:0] fb [FL];

  always #8 clk = ~clk;

  // Free-running cycle number used for the ena latency check.
  always @(posedge clk) cyc <= cyc + 1;

  mic_lag_estimator_if #(.SAMPLE_W(SW), .ACC_W(AC)) bus (.clk(clk));

  mic_lag_estimator #(.SAMPLE_W(SW), .FRAME_LEN(FL), .MAX_LAG(ML)) dut (
    .clk_60MHz    (clk),
    .rst          (rst),
    .sample_valid (bus.sample_valid),
    .mic_a        (bus.mic_a),
    .mic_b        (bus.mic_b),
    .lag_diff     (bus.lag_diff),
    .ena          (bus.ena),
    .peak_corr    (bus.peak_corr),
    .busy         (bus.busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // b[n] = a[n-d]; d > 0 means B lags A.
  task automatic make_frame(input int d, input bit zero);
    for (int n = 0; n < FL; n++) begin
      fa[n] = zero ? '0 : xs[n+20];
      fb[n] = zero ? '0 : xs[n+20-d];
    end
  endtask

  function automatic longint corr(input int k);
    longint s = 0;
    for (int n = 0; n < FL; n++)
      if (n + k >= 0 && n + k < FL) s += longint'(fa[n]) * longint'(fb[n+k]);
    return s;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(output exp_t e);
    longint best = corr(-ML);
    int     bk = -ML;
    for (int k = -ML + 1; k <= ML; k++) begin
      longint r = corr(k);
      if (r > best || (r == best && iabs(k) < iabs(bk))) begin
        best = r;
        bk = k;
      end
    end
    e.lag  = 64'(bk);
    e.peak = best;
    e.cap  = 0;
  endtask

  task automatic send_frame(input bit push);
    exp_t e;
    int   cap = 0;
    for (int n = 0; n < FL; n++) begin
      @(posedge clk); #1;
      bus.sample_valid = 1'b1;
      bus.mic_a = fa[n];
      bus.mic_b = fb[n];
      if (n == FL - 1) cap = cyc;
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
    end
    if (push) begin
      model(e);
      e.cap = cap;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_ena();
    int start = ena_seen;
    int k = 0;
    while (ena_seen == start && k < L + 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ena_arrived", 64'(ena_seen != start), 1);
  endtask

  // Scoreboard: every ena pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ena === 1'b1) begin
      exp_t e;
      ena_seen <= ena_seen + 1;
      chk("ena_pending", 64'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("lag_diff", 64'(bus.lag_diff), e.lag);
        chk("peak_corr", 64'(bus.peak_corr), e.peak);
        chk("ena_latency", 64'(cyc - e.cap), 64'(L));
        chk("lag_range", 64'(bus.lag_diff >= -ML && bus.lag_diff <= ML), 1);
      end
    end
  end

  initial begin
    int k;
    int seen0;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.mic_a = '0;
    bus.mic_b = '0;
    for (int i = 0; i < FL + 40; i++) xs[i] = SW'($urandom);
    xs[40] = 16'sh7FFF;
    xs[41] = 16'sh8000;
    xs[42] = 16'sh8000;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_lag", 64'(bus.lag_diff), 0);
    chk("rst_peak", 64'(bus.peak_corr), 0);
    chk("rst_ena", 64'(bus.ena), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    rst = 1'b0;

    // B lags A by 3.
    make_frame(3, 1'b0);
    send_frame(1'b1);
    chk("busy_compute", 64'(bus.busy), 1);
    wait_ena();
    chk("lag_p3", 64'(bus.lag_diff), 3);

    // A lags B by 5.
    make_frame(-5, 1'b0);
    send_frame(1'b1);
    wait_ena();
    chk("lag_m5", 64'(bus.lag_diff), -5);
    chk("lag_m5_bits", {58'd0, bus.lag_diff}, 64'd59);

    // Silent frame.
    make_frame(0, 1'b1);
    send_frame(1'b1);
    wait_ena();
    chk("zero_lag", 64'(bus.lag_diff), 0);
    chk("zero_peak", 64'(bus.peak_corr), 0);

    // Delay beyond the search window.
    make_frame(12, 1'b0);
    send_frame(1'b1);
    wait_ena();

    // Full-scale strobes during COMPUTE and DONE must be ignored.
    make_frame(3, 1'b0);
    send_frame(1'b1);
    bus.mic_a = 16'sh7FFF;
    bus.mic_b = 16'sh7FFF;
    bus.sample_valid = 1'b1;
    k = 0;
    while (bus.ena !== 1'b1 && k < L + 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("strobe_run_ena", 64'(k < L + 100), 1);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    chk("hold_lag", 64'(bus.lag_diff), 3);
    make_frame(-2, 1'b0);
    send_frame(1'b1);
    wait_ena();
    chk("lag_m2", 64'(bus.lag_diff), -2);

    // Reset in the middle of COMPUTE aborts the frame.
    make_frame(5, 1'b0);
    send_frame(1'b0);
    repeat (1500) @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_lag", 64'(bus.lag_diff), 0);
    chk("abort_peak", 64'(bus.peak_corr), 0);
    chk("abort_ena", 64'(bus.ena), 0);
    chk("abort_busy0", 64'(bus.busy), 0);
    rst = 1'b0;
    seen0 = ena_seen;
    repeat (L + 50) @(posedge clk);
    #1;
    chk("abort_no_ena", 64'(ena_seen), 64'(seen0));
    make_frame(2, 1'b0);
    send_frame(1'b1);
    wait_ena();
    chk("lag_p2", 64'(bus.lag_diff), 2);

    repeat (4) @(posedge clk);
    chk("sb_empty", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mic_lag_estimator.md
MIC_LAG_ESTIMATOR -- requirements
Module: mic_lag_estimator

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: signed PCM sample width per microphone.
REQ-002 SHALL have parameter FRAME_LEN, default 256: sample pairs per correlation frame (power of two).
REQ-003 SHALL have parameter MAX_LAG, default 8: largest lag magnitude searched; legal range 1..31.
REQ-004 SHALL have port clk_60MHz, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous to clk_60MHz, active-high.
REQ-006 SHALL have port sample_valid, input, 1 bit: one-cycle strobe at fs (31250 Hz) marking a new sample pair.
REQ-007 SHALL have port mic_a, input, SAMPLE_W bits, signed: microphone A sample, qualified by sample_valid.
REQ-008 SHALL have port mic_b, input, SAMPLE_W bits, signed: microphone B sample, qualified by sample_valid.
REQ-009 SHALL have port lag_diff, output, 6 bits, signed: best lag in samples; feeds the angle stage directly.
REQ-010 SHALL have port ena, output, 1 bit: one-cycle pulse marking a new lag_diff.
REQ-011 SHALL have port peak_corr, output, ACC_W bits, signed: correlation value at the chosen lag.
REQ-012 SHALL have port busy, output, 1 bit: high in COMPUTE; sample pairs are ignored while high.

Function
REQ-013 SHALL implement an FSM with states FILL, COMPUTE and DONE, entering FILL after reset.
REQ-014 FILL SHALL write each sample_valid pair to buffers A and B at index n = 0..FRAME_LEN-1; the capture of index FRAME_LEN-1 SHALL move the FSM to COMPUTE on the next cycle.
REQ-015 COMPUTE SHALL evaluate R(k) = sum over n of a[n]*b[n+k] for k = -MAX_LAG..+MAX_LAG in ascending order; terms with n+k outside 0..FRAME_LEN-1 SHALL contribute zero.
REQ-016 The sign convention SHALL be: positive k means the sound reaches A first (B lags A).
REQ-017 Products SHALL be 2*SAMPLE_W bits signed; the accumulator SHALL be ACC_W = 2*SAMPLE_W + log2(FRAME_LEN) bits signed and SHALL NOT saturate.
REQ-018 There SHALL be one MAC per cycle; each lag SHALL cost exactly FRAME_LEN+3 cycles (read, multiply, accumulate drain, compare).
REQ-019 Argmax SHALL replace the best value when R(k) > best, or when R(k) == best and |k| < |best_k|; the initial best SHALL be R(-MAX_LAG).
REQ-020 DONE SHALL last one cycle: register lag_diff and peak_corr, pulse ena, then return to FILL with the write index at 0.
REQ-021 ena SHALL rise exactly L = (2*MAX_LAG+1)*(FRAME_LEN+3)+1 cycles after the cycle capturing index FRAME_LEN-1.
REQ-022 lag_diff and peak_corr SHALL hold until the next DONE.
REQ-023 lag_diff SHALL always lie within -MAX_LAG..+MAX_LAG and SHALL never wrap.
REQ-024 sample_valid SHALL be ignored during COMPUTE and DONE; no buffer write occurs.
REQ-025 sample_valid coincident with DONE SHALL be dropped; the first capture SHALL be the next strobe in FILL.

Reset
REQ-026 While rst is high: state = FILL, write index = 0, accumulator and best registers = 0, lag_diff = 0, peak_corr = 0, ena = 0, busy = 0.
REQ-027 rst asserted mid-FILL or mid-COMPUTE SHALL abort the frame with no ena pulse; buffer contents need not be cleared.

Structure
REQ-028 Package mic_array_pkg SHALL hold SAMPLE_W, FRAME_LEN, MAX_LAG, LAG_W = 6, the ACC_W derivation and the FSM state enum.
REQ-029 The two buffers SHALL be FRAME_LEN x SAMPLE_W simple dual-port memories, inferable as block RAM.
REQ-030 Sub-module xcorr_mac SHALL contain the multiply, accumulate and clear pipeline; the FSM, addressing and argmax SHALL stay in the top level.

Verification
REQ-031 Random full-scale frame with b[n] = a[n-3] -> one ena pulse exactly L cycles after the last capture, lag_diff = +3.
REQ-032 Frame with a[n] = b[n-5] -> lag_diff = -5 (6'b111011), peak_corr equal to the model R(-5).
REQ-033 All-zero frame -> lag_diff = 0, peak_corr = 0.
REQ-034 Delay of 12 with MAX_LAG = 8 -> lag_diff within -8..+8, matching the model argmax, no wrap.
REQ-035 Sample pairs of 16'h7FFF driven during COMPUTE -> result identical to the undisturbed run; the next frame starts at the first strobe after ena.
REQ-036 rst pulsed mid-COMPUTE -> no ena, all outputs 0; the following full frame with a delay of +2 -> lag_diff = +2.
